// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: field-level request channel plus
// the encoded-word response channel, each with its own valid/ready pair.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction packer: S1 registers fields and range-checks the
// immediate, S2 registers the packed word. Statistics under IMM_ENCODER_STATS_EN.
module imm_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  parameter int          STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_encoder_if.slave      bus,
  output logic [STAT_W-1:0] stat_count,
  output logic [STAT_W-1:0] stat_errs
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  logic        s1_valid, s2_valid;
  logic        s1_adv, s2_adv;
  logic        req_err, s1_err;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_funct3;
  logic [31:0] s1_imm;
  logic [31:0] packed_word;
  logic [31:0] instr_q;
  logic        err_q;

  // Backpressure ripples combinationally from out_ready so a full pipe still
  // accepts a new request in the same cycle it delivers one.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_err = 1'b1;
    case (bus.fmt)
      FMT_I, FMT_S: req_err = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
      FMT_B:        req_err = !((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0];
      FMT_U:        req_err = |bus.imm[11:0];
      FMT_J:        req_err = !((&bus.imm[31:20]) || !(|bus.imm[31:20])) || bus.imm[0];
      default:      req_err = 1'b1;
    endcase
  end

  always_comb begin
    packed_word = NOP_WORD;
    case (s1_fmt)
      FMT_I: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                            s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                            s1_rd, s1_opcode};
      default: packed_word = NOP_WORD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      instr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= bus.in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        instr_q <= s1_err ? NOP_WORD : packed_word;
        err_q   <= s1_err;
      end
    end
  end

  // NOTE: the S1 payload is qualified by s1_valid, so it carries no reset and
  // its stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      s1_fmt    <= bus.fmt;
      s1_opcode <= bus.opcode;
      s1_rd     <= bus.rd;
      s1_rs1    <= bus.rs1;
      s1_rs2    <= bus.rs2;
      s1_funct3 <= bus.funct3;
      s1_imm    <= bus.imm;
      s1_err    <= req_err;
    end
  end

`ifdef IMM_ENCODER_STATS_EN
  logic out_fire;
  assign out_fire = s2_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_count <= '0;
      stat_errs  <= '0;
    end else if (out_fire) begin
      if (!(&stat_count))        stat_count <= stat_count + 1'b1;
      if (err_q && !(&stat_errs)) stat_errs <= stat_errs + 1'b1;
    end
  end
`else
  assign stat_count = '0;
  assign stat_errs  = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus randomized traffic
// checked against an arithmetic reference model; honours IMM_ENCODER_STATS_EN.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] stat_count, stat_errs;

  imm_encoder_if bus ();

  imm_encoder #(.NOP_WORD(32'h0000_0013), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .stat_count(stat_count), .stat_errs(stat_errs)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic in_fire;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          got_cyc_q[$];
  int          mdl_cnt, mdl_err;

  // Reference: legality from signed ranges and divisibility, packing from the
  // RV32I field layout.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [31:0] imm);
    longint s;
    logic err;
    logic [31:0] w;
    s = longint'($signed(imm));
    w = 32'h0000_0013;
    case (f)
      3'd0: begin err = (s < -2048 || s > 2047);
                  w = {imm[11:0], rs1, f3, rd, op}; end
      3'd1: begin err = (s < -2048 || s > 2047);
                  w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
      3'd2: begin err = (s < -4096 || s > 4095 || (s % 2) != 0);
                  w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; end
      3'd3: begin err = (imm % 4096) != 0;
                  w = {imm[31:12], rd, op}; end
      3'd4: begin err = (s < -(64'sd1 << 20) || s >= (64'sd1 << 20) || (s % 2) != 0);
                  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; end
      default: err = 1'b1;
    endcase
    if (err) w = 32'h0000_0013;
    return {err, w};
  endfunction

  // One clock of bookkeeping; inputs change 1 time unit after posedge, outputs
  // are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    in_fire = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (got_q.size() < exp_q.size() && exp_q[got_q.size()][32]) begin
        if (mdl_err < 65535) mdl_err++;
      end
      if (mdl_cnt < 65535) mdl_cnt++;
      got_q.push_back({bus.out_err, bus.out_instr});
      got_cyc_q.push_back(cyc);
    end
    if (in_fire)
      exp_q.push_back(model(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.imm));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [31:0] imm);
    bus.fmt = f; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1;
    bus.rs2 = rs2; bus.funct3 = f3; bus.imm = imm; bus.in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [31:0] imm);
    int n;
    set_req(f, op, rd, rs1, rs2, f3, imm);
    n = 0;
    do begin tick(); n++; end while (!in_fire && n < 50);
    if (!in_fire) begin
      miscompares++;
      $display("FAIL send_timeout: request not accepted after %0d cycles, required accept", n);
    end
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin tick(); n++; end
    if (got_q.size() < exp_q.size()) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    mdl_cnt = 0; mdl_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.out_valid, bus.out_err, bus.out_instr, stat_count, stat_errs} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b err=%b instr=%h cnt=%h errs=%h, required all 0",
               bus.out_valid, bus.out_err, bus.out_instr, stat_count, stat_errs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    mdl_cnt = 0; mdl_err = 0;
  endtask

  task automatic test_latency();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_accept: in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", bus.out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({bus.out_valid, bus.out_err, bus.out_instr} !== {1'b1, 1'b0, 32'h0050_0093}) begin
      miscompares++;
      $display("FAIL latency_word: valid=%b err=%b instr=%h, required 1 0 00500093",
               bus.out_valid, bus.out_err, bus.out_instr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [32:0] want [4];
    want = '{{1'b0, 32'h0020_A423}, {1'b0, 32'hFE00_0EE3},
             {1'b0, 32'h1234_52B7}, {1'b0, 32'h0010_00EF}};
    do_reset();
    bus.out_ready = 1'b1;
    send(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
    send(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    drain();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= got_q.size() || got_q[i] !== want[i]) begin
        miscompares++;
        $display("FAIL b2b_word%0d: got %h, required %h", i,
                 (i < got_q.size()) ? got_q[i] : 33'h0, want[i]);
      end else if (i > 0 && got_cyc_q[i] != got_cyc_q[i-1] + 1) begin
        miscompares++;
        $display("FAIL b2b_rate%0d: delivered cycle %0d, required %0d", i,
                 got_cyc_q[i], got_cyc_q[i-1] + 1);
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    bus.out_ready = 1'b1;
    send(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 32'd2048);
    send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    send(3'd3, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'h0000_0001);
    send(3'd5, 7'h7F, 5'd9, 5'd9, 5'd9, 3'd7, 32'd0);
    drain();
    vectors++;
    if (got_q.size() != 4) begin
      miscompares++;
      $display("FAIL err_count: got %0d words, required 4", got_q.size());
    end
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i] !== {1'b1, 32'h0000_0013}) begin
        miscompares++;
        $display("FAIL err_case%0d: got %h, required 100000013", i, got_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] want [3];
    want = '{{1'b0, 32'h0050_0093}, {1'b0, 32'h0020_A423}, {1'b0, 32'h1234_52B7}};
    do_reset();
    bus.out_ready = 1'b0;
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    send(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    set_req(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if ({bus.in_ready, bus.out_valid, bus.out_instr} !== {1'b0, 1'b1, 32'h0050_0093}) begin
        miscompares++;
        $display("FAIL bp_stall: in_ready=%b out_valid=%b instr=%h, required 0 1 00500093",
                 bus.in_ready, bus.out_valid, bus.out_instr);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    drain();
    vectors++;
    if (got_q.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words, required 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== want[i]) begin
        miscompares++;
        $display("FAIL bp_order%0d: got %h, required %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.out_ready = 1'b0;
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    send(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    set_req(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_valid: out_valid=%b after reset, required 0", bus.out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    mdl_cnt = 0; mdl_err = 0;
    send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    drain();
    repeat (3) tick();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 32'h0010_00EF}) begin
      miscompares++;
      $display("FAIL rst_mid_flush: got %0d words first=%h, required 1 word 0001000EF",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 33'h0);
    end
  endtask

  task automatic test_random();
    int edges [8];
    edges = '{-2048, 2047, -4096, 4094, -(1 << 20), (1 << 20) - 2, 2048, 4096};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.fmt    = 3'($urandom_range(0, 7));
      bus.opcode = 7'($urandom); bus.rd = 5'($urandom);
      bus.rs1 = 5'($urandom); bus.rs2 = 5'($urandom); bus.funct3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: bus.imm = $urandom;
        1: bus.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: bus.imm = 32'(edges[$urandom_range(0, 7)] + int'($urandom_range(0, 2)) - 1);
        default: bus.imm = $urandom & 32'hFFFF_F000;
      endcase
      tick();
    end
    bus.out_ready = 1'b1;
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
`ifdef IMM_ENCODER_STATS_EN
    vectors++;
    if (stat_count !== 16'(mdl_cnt) || stat_errs !== 16'(mdl_err)) begin
      miscompares++;
      $display("FAIL rand_stats: cnt=%0d errs=%0d, required %0d %0d",
               stat_count, stat_errs, mdl_cnt, mdl_err);
    end
`endif
  endtask

  task automatic test_stats();
    do_reset();
    bus.out_ready = 1'b1;
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096);
    send(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    send(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    drain();
`ifdef IMM_ENCODER_STATS_EN
    vectors++;
    if (stat_count !== 16'd5 || stat_errs !== 16'd2) begin
      miscompares++;
      $display("FAIL stats_basic: cnt=%0d errs=%0d, required 5 2", stat_count, stat_errs);
    end
    set_req(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    repeat (65540) tick();
    drain();
    vectors++;
    if (stat_count !== 16'hFFFF || stat_errs !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL stats_sat: cnt=%h errs=%h, required ffff ffff", stat_count, stat_errs);
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
`else
    vectors++;
    if (stat_count !== 16'd0 || stat_errs !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_tied: cnt=%h errs=%h, required 0 0", stat_count, stat_errs);
    end
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0;
    bus.rs2 = '0; bus.funct3 = '0; bus.imm = '0;
    mdl_cnt = 0; mdl_err = 0;
    rst_n = 1'b0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the pipeline's immediate decoder. Takes an instruction's fields plus a 32-bit immediate and a format select, and packs them into a 32-bit RV32I instruction word.
- Range-checks and alignment-checks the immediate.
- Used by the self-test / instruction-injection path to build instructions on the fly in front of the fetch mux.
- Two-stage valid/ready pipeline; throughput of one instruction per cycle.

Parameters:
- NOP_WORD, 32'h00000013, word emitted when the encode is invalid (addi x0,x0,0).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- fmt  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 illegal.
- opcode  in  7  instr[6:0].
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  instr[14:12].
- imm  in  32  immediate value, two's complement, byte offset for B/J.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_err  out  1  encode invalid; out_instr = NOP_WORD.
- stat_count  out  STAT_W  instructions delivered (optional feature).
- stat_errs  out  STAT_W  invalid encodes delivered (optional feature).

Behaviour:
- Reset (rst_n=0 at a clock edge): both stage-valid flags clear. out_valid=0, out_instr=0, out_err=0, stat_count=0, stat_errs=0. in_ready=1 in the cycle after reset. Reset asserted mid-operation discards all in-flight words.
- Handshake: transfer on valid&ready at each end. Inputs are sampled only on transfer. out_instr and out_err hold stable while out_valid=1 and out_ready=0.
- Stage 1 (S1) registers the request and computes err:
  - I, S: err if imm[31:11] is not all equal (imm outside −2048..2047).
  - B: err if imm[31:12] is not all equal or imm[0]=1.
  - U: err if imm[11:0]≠0.
  - J: err if imm[31:20] is not all equal or imm[0]=1.
  - fmt 101–111: err=1.
- Stage 2 (S2) registers the packed word:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - If err: out_instr=NOP_WORD and out_err=1.
- Unused fields for a format are ignored (e.g. rs2 for I, rd for S/B).
- Latency: 2 cycles from input transfer to out_valid with out_ready held high.
- Flow control:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | S2 advances.
  - in_ready = !s1_valid | S2 advances (combinational from out_ready, no bubbles).
- Full stall: both stages hold and in_ready=0. Order is always preserved and no word is lost or duplicated.
- Simultaneous events: input accepted and output delivered in the same cycle is legal at full rate.

Optional Feature:
- Macro: IMM_ENCODER_STATS_EN.
- Defined:
  - stat_count increments on each output transfer.
  - stat_errs increments on each output transfer with out_err=1.
  - Both saturate at all-ones and do not wrap.
  - Both are cleared by reset.
- Undefined: the stat ports are present but tied to 0, and no counter flops are built.

Test Plan:
- I fmt, opcode 0x13, rd 1, rs1 0, funct3 0, imm 5 → out_instr 0x00500093, out_err 0, out_valid 2 cycles after accept.
- Full-rate back-to-back sequence, out_ready=1:
  - S: opc 0x23, f3 2, rs1 1, rs2 2, imm 8 → 0x0020A423.
  - B: opc 0x63, imm −4 → 0xFE000EE3.
  - U: opc 0x37, rd 5, imm 0x12345000 → 0x123452B7.
  - J: opc 0x6F, rd 1, imm 2048 → 0x001000EF.
  - Required: one result per cycle, in order.
- Error cases: I imm 2048; B imm 3; U imm 0x00000001; fmt 101 → each gives out_instr 0x00000013, out_err 1.
- Backpressure: 3 requests with out_ready=0 → in_ready drops after 2 accepts and out_instr stays stable. Release out_ready → 3 words delivered in order, none lost.
- Reset: assert rst_n=0 with both stages full → out_valid=0 next cycle and nothing from before reset appears afterwards.
- With IMM_ENCODER_STATS_EN: 5 deliveries including 2 errors → stat_count=5, stat_errs=2. Preload near all-ones → counters saturate at 0xFFFF. Without the macro → stat ports read 0.
